ms_data_arb: RTL
================

MS_DATA_ARB -- requirements
Module: ms_data_arb

Interface
REQ-001 SHALL have parameter CReqCnt, default 3, number of data requesters (2..8).
REQ-002 SHALL have parameter CTimeout, default 255, max AMemBusy cycles before abort (1..255).
REQ-003 SHALL have port AClkH input 1: single clock; all logic rising-edge.
REQ-004 SHALL have port AResetH input 1: synchronous, active-high reset.
REQ-005 SHALL have port AClkHEn input 1: clock enable; state advances only when 1.
REQ-006 SHALL have port AReqAddr input CReqCnt*32: per-requester byte address, requester i at [i*32+31:i*32].
REQ-007 SHALL have port AReqMosi input CReqCnt*64: per-requester write data.
REQ-008 SHALL have ports AReqWrSize, AReqRdSize input CReqCnt*4: per-requester byte count; nonzero = request.
REQ-009 SHALL have port AReqAck output CReqCnt: one-hot completion pulse.
REQ-010 SHALL have port AReqMiso output 64: registered read data, common to all requesters.
REQ-011 SHALL have ports AMemAddr output 32, AMemMosi output 64, AMemWrSize output 4, AMemRdSize output 4: shared downstream command.
REQ-012 SHALL have port AMemMiso input 64 and AMemBusy input 1: downstream read data and busy.
REQ-013 SHALL have port AErr output 1: timeout pulse.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK; all transitions gated by AClkHEn.
REQ-015 IDLE SHALL pick the first active requester searching from (LastGrant+1) mod CReqCnt upward with wrap; none active -> stay IDLE.
REQ-016 On a pick, SHALL latch the winner's index, addr, mosi and sizes, update LastGrant, and go ISSUE.
REQ-017 ISSUE SHALL drive the latched command on AMem* for exactly one enabled cycle, then go WAIT.
REQ-018 Outside ISSUE, AMemWrSize and AMemRdSize SHALL be 0; AMemAddr/AMemMosi SHALL hold the last latched value.
REQ-019 WAIT SHALL stay while AMemBusy=1; on AMemBusy=0 SHALL capture AMemMiso into AReqMiso (only if latched RdSize nonzero) and go ACK.
REQ-020 ACK SHALL assert AReqAck[winner] for one enabled cycle, then go IDLE.
REQ-021 Minimum latency: request visible in IDLE at cycle N -> AReqAck high at cycle N+3.
REQ-022 Requesters SHALL hold request and operands until the cycle after ack; a request dropped before ack after being latched SHALL still complete.
REQ-023 Request with both WrSize and RdSize nonzero SHALL be forwarded unchanged as one transaction.
REQ-024 When AClkHEn=0, outputs SHALL hold and an ack pulse SHALL stretch until the next enabled cycle.
REQ-025 AReqAck SHALL be one-hot or zero at all times.

Reset
REQ-026 AResetH=1 SHALL force IDLE, LastGrant=CReqCnt-1 (requester 0 wins first), AReqAck=0, AReqMiso=0, AMemAddr=0, AMemMosi=0, AMemWrSize=0, AMemRdSize=0, AErr=0, timeout counter 0, regardless of AClkHEn.
REQ-027 Reset mid-transaction SHALL abandon it with no ack.

Configuration
REQ-028 Macro MS_DATA_ARB_TIMEOUT_EN defined: 8-bit counter clears on WAIT entry, increments per enabled WAIT cycle with AMemBusy=1; reaching CTimeout SHALL go ACK with AReqMiso=0 and AErr=1 for that ACK cycle.
REQ-029 Macro undefined: no counter, WAIT indefinitely, AErr tied 0.

Verification
REQ-030 Single: req1 RdSize=8, addr 0x100, AMemBusy=0, AMemMiso=0x1122334455667788 -> AMemRdSize=8 at N+1, AReqAck=3'b010 at N+3, AReqMiso=0x1122334455667788.
REQ-031 Contention: all three request after reset -> acks in order 0,1,2, each 4 cycles apart; re-request 0 and 2 -> 0 then 2.
REQ-032 Busy: AMemBusy=1 for 5 cycles after ISSUE -> ack at N+8; AMem sizes 0 during WAIT.
REQ-033 Clock enable: AClkHEn toggled 1/0 -> all transitions and ack each take two cycles; results match REQ-030.
REQ-034 Timeout (macro on, CTimeout=4): AMemBusy stuck 1 -> ack and AErr=1 after 4 busy cycles, AReqMiso=0; macro off -> no ack.
REQ-035 Reset in WAIT: AResetH=1 one cycle -> all outputs 0, no ack, next grant to requester 0.

Source files
------------

// File: rtl/ms_data_arb.sv
// Round-robin arbiter: several data requesters share one downstream memory port, one transaction at a time.
// Optional busy timeout: define MS_DATA_ARB_TIMEOUT_EN.
module ms_data_arb_lane (
   input  logic [3:0] wrSize,
   input  logic [3:0] rdSize,
   output logic       active
);
   assign active = (wrSize != 4'd0) || (rdSize != 4'd0);
endmodule

module ms_data_arb #(
   parameter int CReqCnt  = 3,
   parameter int CTimeout = 255
) (
   input  logic                   AClkH,
   input  logic                   AResetH,
   input  logic                   AClkHEn,
   input  logic [CReqCnt*32-1:0]  AReqAddr,
   input  logic [CReqCnt*64-1:0]  AReqMosi,
   input  logic [CReqCnt*4-1:0]   AReqWrSize,
   input  logic [CReqCnt*4-1:0]   AReqRdSize,
   output logic [CReqCnt-1:0]     AReqAck,
   output logic [63:0]            AReqMiso,
   output logic [31:0]            AMemAddr,
   output logic [63:0]            AMemMosi,
   output logic [3:0]             AMemWrSize,
   output logic [3:0]             AMemRdSize,
   input  logic [63:0]            AMemMiso,
   input  logic                   AMemBusy,
   output logic                   AErr
);
   localparam int CIdxW = $clog2(CReqCnt);

   if (CReqCnt < 2 || CReqCnt > 8 || CTimeout < 1 || CTimeout > 255) begin : gBadParam
      $error("ms_data_arb: CReqCnt must be 2..8 and CTimeout 1..255");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_t;

   state_t                     state, stateNxt;
   logic [CReqCnt-1:0]         reqActive;
   logic [CReqCnt-1:0][31:0]   reqAddr;
   logic [CReqCnt-1:0][63:0]   reqMosi;
   logic [CReqCnt-1:0][3:0]    reqWr, reqRd;
   // lastGrant doubles as the current winner once a pick has been made
   logic [CIdxW-1:0]           lastGrant;
   logic [31:0]                latAddr;
   logic [63:0]                latMosi;
   logic [3:0]                 latWr, latRd;
   logic                       pickValid;
   logic [CIdxW-1:0]           pickIdx;

   for (genvar i = 0; i < CReqCnt; i++) begin : gLane
      assign reqAddr[i] = AReqAddr[i*32 +: 32];
      assign reqMosi[i] = AReqMosi[i*64 +: 64];
      assign reqWr[i]   = AReqWrSize[i*4 +: 4];
      assign reqRd[i]   = AReqRdSize[i*4 +: 4];
      ms_data_arb_lane uLane (
         .wrSize (reqWr[i]),
         .rdSize (reqRd[i]),
         .active (reqActive[i])
      );
      assign AReqAck[i] = (state == StAck) && (lastGrant == CIdxW'(i));
   end

   // Search starts one past the previous winner and wraps
   always_comb begin
      logic [CIdxW:0] j;
      pickValid = 1'b0;
      pickIdx   = '0;
      j         = '0;
      for (int k = 1; k <= CReqCnt; k++) begin
         j = {1'b0, lastGrant} + (CIdxW+1)'(k);
         if (j >= (CIdxW+1)'(CReqCnt)) j = j - (CIdxW+1)'(CReqCnt);
         if (!pickValid && reqActive[j[CIdxW-1:0]]) begin
            pickValid = 1'b1;
            pickIdx   = j[CIdxW-1:0];
         end
      end
   end

`ifdef MS_DATA_ARB_TIMEOUT_EN
   localparam logic [7:0] CToLast = 8'(CTimeout - 1);
   logic [7:0] toCnt;
   logic       errFlag;
   logic       toHit;
   assign toHit = AMemBusy && (toCnt == CToLast);
   assign AErr  = (state == StAck) && errFlag;
`else
   logic toHit;
   assign toHit = 1'b0;
   assign AErr  = 1'b0;
`endif

   always_comb begin
      stateNxt = state;
      case (state)
         StIdle:  if (pickValid) stateNxt = StIssue;
         StIssue: stateNxt = StWait;
         StWait:  if (!AMemBusy || toHit) stateNxt = StAck;
         StAck:   stateNxt = StIdle;
         default: stateNxt = StIdle;
      endcase
   end

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         state     <= StIdle;
         lastGrant <= CIdxW'(CReqCnt - 1);
         latAddr   <= '0;
         latMosi   <= '0;
         latWr     <= '0;
         latRd     <= '0;
         AReqMiso  <= '0;
`ifdef MS_DATA_ARB_TIMEOUT_EN
         toCnt     <= '0;
         errFlag   <= 1'b0;
`endif
      end else if (AClkHEn) begin
         state <= stateNxt;
         case (state)
            StIdle: if (pickValid) begin
               lastGrant <= pickIdx;
               latAddr   <= reqAddr[pickIdx];
               latMosi   <= reqMosi[pickIdx];
               latWr     <= reqWr[pickIdx];
               latRd     <= reqRd[pickIdx];
`ifdef MS_DATA_ARB_TIMEOUT_EN
               errFlag   <= 1'b0;
`endif
            end
`ifdef MS_DATA_ARB_TIMEOUT_EN
            StIssue: toCnt <= '0;
            StWait: begin
               if (!AMemBusy) begin
                  if (latRd != 4'd0) AReqMiso <= AMemMiso;
               end else if (toHit) begin
                  AReqMiso <= '0;
                  errFlag  <= 1'b1;
               end else begin
                  toCnt <= toCnt + 8'd1;
               end
            end
`else
            StWait: if (!AMemBusy && latRd != 4'd0) AReqMiso <= AMemMiso;
`endif
            default: ;
         endcase
      end
   end

   // Sizes qualify the command; address/data simply hold the last latch
   assign AMemAddr   = latAddr;
   assign AMemMosi   = latMosi;
   assign AMemWrSize = (state == StIssue) ? latWr : 4'd0;
   assign AMemRdSize = (state == StIssue) ? latRd : 4'd0;
endmodule
